expand_a_sink: RTL
==================

# expand_a_sink

Downstream consumer and sequencer for the uniform matrix-A rejection sampler. Walks the K×L polynomial indices (i outer, j inner), triggers the sampler for each polynomial, and accepts its BUS_W-wide coefficient stream. Writes each beat into the matrix-A RAM through a registered write port. Signals completion when the whole matrix is stored.

## Interface
- K, 4: matrix rows (1..8).
- L, 4: matrix columns (1..8).
- SAMPLE_W, 23: coefficient width.
- BUS_W, 4: coefficients per beat.
- ADDR_W, 10: RAM word address width; must satisfy 2^ADDR_W ≥ K·L·(256/BUS_W).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin matrix expansion; ignored unless IDLE.
- base_addr  in  ADDR_W  RAM base, sampled on start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the final RAM write.
- err  out  1  sticky protocol/range error, cleared on accepted start.
- smp_start  out  1  one-cycle pulse that requests the first polynomial and loads the seed.
- smp_resample  out  1  one-cycle pulse that requests later polynomials, reusing the stored seed.
- smp_i  out  4  row index of the current polynomial.
- smp_j  out  4  column index of the current polynomial.
- smp_samples  in  SAMPLE_W·BUS_W  coefficient beat; lane 0 in the LSBs.
- smp_valid  in  1  beat valid.
- smp_ready  out  1  beat accepted when smp_valid and smp_ready are both high.
- smp_done  in  1  sampler end-of-polynomial indication, coincident with the final handshake.
- mem_gnt  in  1  RAM write port granted this cycle.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  SAMPLE_W·BUS_W  write data.

## Operation
- States: IDLE, ISSUE, STREAM, NEXT, FIN.
- IDLE:
  - Outputs are idle.
  - start → ISSUE.
  - On start: latch base_addr; clear i, j, beat_ctr, err; clear first_done.
- ISSUE, one cycle:
  - Pulse smp_start if first_done=0, otherwise pulse smp_resample.
  - Set first_done.
  - → STREAM.
- STREAM:
  - smp_ready = mem_gnt (combinational).
  - On each handshake:
    - register mem_we=1;
    - mem_addr = base + (i·L+j)·(256/BUS_W) + beat_ctr, truncated to ADDR_W;
    - mem_wdata = smp_samples;
    - beat_ctr increments by 1 and wraps modulo 256/BUS_W.
  - Handshake with beat_ctr = last → NEXT.
  - smp_done on a handshake whose beat_ctr ≠ last → set err; the polynomial continues until the beat count is complete.
  - Last handshake without smp_done → set err; still → NEXT.
- NEXT, one cycle:
  - if j = L−1 then j ← 0 and i ← i+1; otherwise j ← j+1.
  - If i = K−1 and j = L−1 before the increment → FIN; otherwise → ISSUE.
- FIN, one cycle:
  - Pulse done; the final write has already been issued in the preceding NEXT cycle.
  - → IDLE.
- smp_i and smp_j hold the current indices in all states.

## Timing
- Reset values: every output 0, state IDLE, all counters 0, first_done 0.
- Reset mid-operation: any in-flight registered write is dropped (mem_we=0 on the next cycle). The sampler is not reset by this block.
- smp_start or smp_resample is asserted exactly 1 cycle after start (or after NEXT).
- Write latency: handshake in cycle n → mem_we high in cycle n+1. mem_we is high for exactly one cycle per beat.
- mem_gnt low stalls acceptance with no lost beats; this block never buffers beats.
- Per-polynomial overhead: 2 cycles (NEXT and ISSUE) plus the sampler's own latency.
- start during busy: ignored, no effect.
- smp_valid outside STREAM: ignored; smp_ready stays 0.

## Configuration
- RANGE_CHECK_EN:
  - Defined: each lane of every accepted beat is compared against Q = 8380417; any lane ≥ Q sets err. The beat is still written.
  - Undefined: no comparators are built; err reflects protocol errors only.

## Structure
- Shared package dilithium_pkg holds:
  - Q = 8380417;
  - SAMPLE_W;
  - the state encoding of this block;
  - the function poly_base(i, j, L) returning (i·L+j)·64.
- No sub-module. The range check is an inline per-lane generate loop.

## Test plan
- **Full matrix:** K=4, L=4, base=0, mem_gnt=1, sampler model emits lanes {4c+3, 4c+2, 4c+1, 4c} per beat c → 1024 writes at addresses 0..1023, data as sent; one smp_start then 15 smp_resample pulses; done exactly once; err=0.
- **Backpressure:** mem_gnt pseudo-random at 50% → smp_ready tracks mem_gnt; no beat dropped or duplicated; all addresses contiguous.
- **Index order and base:** K=2, L=3, base=100 → (i,j) sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); polynomial (1,2) is written at addresses 420..483.
- **Protocol error:** smp_done asserted on beat 10 → err=1; expansion still completes; the next start clears err.
- **Range check (RANGE_CHECK_EN):** lane 2 = 8380417 → err=1; lane = 8380416 → err stays 0. Without the macro, the same stimulus leaves err=0.
- **Reset mid-stream:** rst at beat 30 of polynomial (0,1) → all outputs 0 on the next cycle; a subsequent start restarts at (0,0) using smp_start.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared constants, state encoding and address helper for the Dilithium
// matrix-A expansion blocks.
package dilithium_pkg;

  localparam int unsigned Q        = 32'd8380417;
  localparam int          SAMPLE_W = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_STREAM,
    ST_NEXT,
    ST_FIN
  } eas_state_t;

  // Word offset of polynomial (i, j) for 64 beats per polynomial.
  function automatic int poly_base(input int i, input int j, input int l);
    return (i * l + j) * 64;
  endfunction

endpackage

// File: rtl/expand_a_sink.sv
// Sequencer and sink for the matrix-A rejection sampler: walks (i, j), stores
// each coefficient beat through a registered RAM write port. Optional macro
// RANGE_CHECK_EN adds per-lane "coefficient >= Q" checks feeding err.
module expand_a_sink #(
  parameter int K        = 4,
  parameter int L        = 4,
  parameter int SAMPLE_W = dilithium_pkg::SAMPLE_W,
  parameter int BUS_W    = 4,
  parameter int ADDR_W   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         smp_start,
  output logic                         smp_resample,
  output logic [3:0]                   smp_i,
  output logic [3:0]                   smp_j,
  input  logic [SAMPLE_W*BUS_W-1:0]    smp_samples,
  input  logic                         smp_valid,
  output logic                         smp_ready,
  input  logic                         smp_done,
  input  logic                         mem_gnt,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [SAMPLE_W*BUS_W-1:0]    mem_wdata
);
  import dilithium_pkg::*;

  localparam int BEATS = 256 / BUS_W;
  localparam int CTR_W = $clog2(BEATS);

  eas_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        i_q, j_q;
  logic [CTR_W-1:0]  beat_q;
  logic              first_done_q;
  logic              err_q;
  logic              hs;
  logic              last_beat;
  logic              last_poly;
  logic              range_err;
  int                poly_off;
  logic [ADDR_W-1:0] wr_addr;

  assign hs        = smp_valid & smp_ready;
  assign last_beat = (beat_q == CTR_W'(BEATS - 1));
  assign last_poly = (i_q == 4'(K - 1)) && (j_q == 4'(L - 1));

  // The package helper assumes 64 beats; other bus widths scale directly.
  always_comb begin
    if (BEATS == 64) poly_off = poly_base(int'(i_q), int'(j_q), L);
    else             poly_off = (int'(i_q) * L + int'(j_q)) * BEATS;
  end

  assign wr_addr = base_q + ADDR_W'(poly_off) + ADDR_W'(beat_q);

`ifdef RANGE_CHECK_EN
  logic [BUS_W-1:0] lane_oor;
  for (genvar g = 0; g < BUS_W; g++) begin : g_range
    assign lane_oor[g] = (smp_samples[g*SAMPLE_W +: SAMPLE_W] >= SAMPLE_W'(Q));
  end
  assign range_err = |lane_oor;
`else
  assign range_err = 1'b0;
`endif

  // NOTE: next state defaults to the current state first so no path through
  // the case leaves state_d unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_STREAM;
      ST_STREAM: if (hs && last_beat) state_d = ST_NEXT;
      ST_NEXT:   state_d = last_poly ? ST_FIN : ST_ISSUE;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN);
  assign smp_start    = (state_q == ST_ISSUE) && !first_done_q;
  assign smp_resample = (state_q == ST_ISSUE) &&  first_done_q;
  assign smp_ready    = (state_q == ST_STREAM) && mem_gnt;
  assign smp_i        = i_q;
  assign smp_j        = j_q;
  assign err          = err_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      i_q          <= '0;
      j_q          <= '0;
      beat_q       <= '0;
      first_done_q <= 1'b0;
      err_q        <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state_q <= state_d;
      mem_we  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q       <= base_addr;
            i_q          <= '0;
            j_q          <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            first_done_q <= 1'b0;
          end
        end
        ST_ISSUE: first_done_q <= 1'b1;
        ST_STREAM: begin
          if (hs) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= smp_samples;
            beat_q    <= beat_q + CTR_W'(1);
            // Early or missing end-of-polynomial and out-of-range lanes are
            // all reported through the same sticky flag.
            if ((smp_done != last_beat) || range_err) err_q <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (j_q == 4'(L - 1)) begin
            j_q <= '0;
            i_q <= i_q + 4'd1;
          end else begin
            j_q <= j_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
